// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral data bus: FSM encoding, alignment rule
// and default widths used by both initiator and responder.
package periph_bus_pkg;

  localparam int unsigned PB_DATA_WIDTH = 32;
  localparam int unsigned PB_ADDR_WIDTH = 10;
  localparam logic [1:0]  PB_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RV = 2'd2,
    ST_RESP    = 2'd3
  } pb_state_e;

  // Only word-aligned accesses go out on the bus.
  function automatic logic pb_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & PB_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Single-outstanding initiator for the req/gnt/rvalid peripheral bus.
// Optional request timeout enabled by defining PERIPH_BUS_MASTER_TIMEOUT_EN.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = PB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = PB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    master_data_req_o,
  output logic [ADDR_WIDTH-1:0]   master_data_addr_o,
  output logic                    master_data_we_o,
  output logic [DATA_WIDTH/8-1:0] master_data_be_o,
  output logic [DATA_WIDTH-1:0]   master_data_wdata_o,
  input  logic                    master_data_gnt_i,
  input  logic                    master_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   master_data_rdata_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  pb_state_e             state_q, state_d;
  cmd_t                  cmd_q;
  rsp_t                  rsp_q, rsp_d;
  logic                  live_q;
  logic                  cmd_fire, cmd_mis, timeout;
  logic [DATA_WIDTH-1:0] capture_rdata;

  assign cmd_fire      = cmd_valid_i & cmd_ready_o;
  assign cmd_mis       = pb_misaligned(cmd_addr_i[1:0]);
  assign capture_rdata = cmd_q.we ? '0 : master_data_rdata_i;

`ifdef PERIPH_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            bus_wait;

  assign bus_wait = (state_q == ST_REQ) || (state_q == ST_WAIT_RV);

  // Held at zero outside the bus phase, so it always starts from 0 on entry to REQ;
  // saturates so a late gnt landing on expiry still times out WAIT_RV next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          to_cnt_q <= '0;
    else if (!bus_wait)                  to_cnt_q <= '0;
    else if (to_cnt_q != TO_LAST)        to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout = bus_wait && (to_cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A bus response that coincides with expiry takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_fire) state_d = cmd_mis ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (master_data_gnt_i) state_d = master_data_rvalid_i ? ST_RESP : ST_WAIT_RV;
        else if (timeout)      state_d = ST_RESP;
      end
      ST_WAIT_RV: if (master_data_rvalid_i || timeout) state_d = ST_RESP;
      ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o       = 1'b0;
    master_data_req_o = 1'b0;
    rsp_valid_o       = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready_o       = live_q;
      ST_REQ:  master_data_req_o = 1'b1;
      ST_RESP: rsp_valid_o       = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rsp_d = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          rsp_d.err   = cmd_mis;
          rsp_d.rdata = '0;
        end
      end
      ST_REQ: begin
        if (master_data_gnt_i) begin
          if (master_data_rvalid_i) rsp_d.rdata = capture_rdata;
        end else if (timeout) begin
          rsp_d.err = 1'b1;
        end
      end
      ST_WAIT_RV: begin
        if (master_data_rvalid_i) rsp_d.rdata = capture_rdata;
        else if (timeout)         rsp_d.err   = 1'b1;
      end
      default: ;
    endcase
  end

  // live_q keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q <= 1'b0;
      cmd_q  <= '0;
      rsp_q  <= '0;
    end else begin
      live_q <= 1'b1;
      rsp_q  <= rsp_d;
      if (cmd_fire) cmd_q <= '{we: cmd_we_i, addr: cmd_addr_i, be: cmd_be_i, wdata: cmd_wdata_i};
    end
  end

  assign master_data_addr_o  = cmd_q.addr;
  assign master_data_we_o    = cmd_q.we;
  assign master_data_be_o    = cmd_q.be;
  assign master_data_wdata_o = cmd_q.wdata;

  assign rsp_rdata_o = rsp_valid_o ? rsp_q.rdata : '0;
  assign rsp_err_o   = rsp_valid_o & rsp_q.err;

endmodule

// File: tb/tb_periph_bus_master.sv
// Randomized bench for periph_bus_master: transaction-level model, bus responder
// with random latencies and stray gnt/rvalid, plus directed latency/reset/timeout cases.
module tb_periph_bus_master;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;
`ifdef PERIPH_BUS_MASTER_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [BW-1:0] cmd_be_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          master_data_req_o, master_data_we_o;
  logic [AW-1:0] master_data_addr_o;
  logic [BW-1:0] master_data_be_o;
  logic [DW-1:0] master_data_wdata_o;
  logic          master_data_gnt_i, master_data_rvalid_i;
  logic [DW-1:0] master_data_rdata_i;

  always #5 clk = ~clk;

  periph_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .master_data_req_o(master_data_req_o), .master_data_addr_o(master_data_addr_o),
    .master_data_we_o(master_data_we_o), .master_data_be_o(master_data_be_o),
    .master_data_wdata_o(master_data_wdata_o), .master_data_gnt_i(master_data_gnt_i),
    .master_data_rvalid_i(master_data_rvalid_i), .master_data_rdata_i(master_data_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: what the master owes the outside world right now.
  bit            m_live, m_busy, m_await_gnt, m_await_rv, m_have_rsp, m_err;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_age;
  bit            chk_en = 1'b0;

  // Responder controls
  int            r_gd = -1, r_rd = 0, f_gd = -1, f_rd = -1, stale_n = 0;
  bit            r_wait_rv = 1'b0, noise_en = 1'b0, f_data_en = 1'b0;
  logic [DW-1:0] f_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready_o, m_live && !m_busy);
      chk("req", master_data_req_o, m_await_gnt);
      if (m_await_gnt) begin
        chk("bus_addr", master_data_addr_o, m_addr);
        chk("bus_we", master_data_we_o, m_we);
        chk("bus_be", master_data_be_o, m_be);
        chk("bus_wdata", master_data_wdata_o, m_wdata);
      end
      chk("rsp_valid", rsp_valid_o, m_have_rsp);
      if (m_have_rsp) begin
        chk("rsp_rdata", rsp_rdata_o, m_rdata);
        chk("rsp_err", rsp_err_o, m_err);
      end
    end
  end

  task automatic m_finish(input logic [DW-1:0] rd);
    m_await_gnt = 0; m_await_rv = 0; m_have_rsp = 1; m_err = 0;
    m_rdata = m_we ? '0 : rd;
  endtask

  task automatic m_expire();
    m_await_gnt = 0; m_await_rv = 0; m_have_rsp = 1; m_err = 1; m_rdata = '0;
  endtask

  task automatic model_update(input bit acc, input bit hs, input bit g, input bit rv,
                              input logic [DW-1:0] rd);
    if (!reset) begin
      m_live = 0; m_busy = 0; m_await_gnt = 0; m_await_rv = 0; m_have_rsp = 0;
      return;
    end
    m_live = 1;
    if (hs) begin m_have_rsp = 0; m_busy = 0; end
    if (m_await_gnt) begin
      if (g) begin
        if (rv) m_finish(rd);
        else begin m_await_gnt = 0; m_await_rv = 1; m_age++; end
      end else if (TO_EN && m_age >= TO - 1) m_expire();
      else m_age++;
    end else if (m_await_rv) begin
      if (rv) m_finish(rd);
      else if (TO_EN && m_age >= TO - 1) m_expire();
      else m_age++;
    end
    if (acc) begin
      m_busy = 1; m_we = cmd_we_i; m_addr = cmd_addr_i; m_be = cmd_be_i; m_wdata = cmd_wdata_i;
      if (cmd_addr_i[1:0] != 2'b00) begin m_have_rsp = 1; m_err = 1; m_rdata = '0; end
      else begin m_await_gnt = 1; m_age = 0; end
    end
  endtask

  function automatic int pick();
    if (TO_EN && $urandom_range(0, 7) == 0) return $urandom_range(4, 12);
    return $urandom_range(0, 3);
  endfunction

  task automatic respond();
    master_data_gnt_i = 0; master_data_rvalid_i = 0; master_data_rdata_i = $urandom;
    if (stale_n > 0) begin
      stale_n--; master_data_gnt_i = 1; master_data_rvalid_i = 1; master_data_rdata_i = 32'hDEAD_BEEF;
      return;
    end
    if (r_wait_rv) begin
      if (r_rd == 0) begin
        master_data_rvalid_i = 1; r_wait_rv = 0;
        if (f_data_en) master_data_rdata_i = f_data;
      end else r_rd--;
    end else if (master_data_req_o) begin
      if (r_gd < 0) begin
        r_gd = (f_gd >= 0) ? f_gd : pick();
        r_rd = (f_rd >= 0) ? f_rd : pick();
      end
      if (r_gd == 0) begin
        master_data_gnt_i = 1; r_gd = -1;
        if (r_rd == 0) begin
          master_data_rvalid_i = 1;
          if (f_data_en) master_data_rdata_i = f_data;
        end else begin r_wait_rv = 1; r_rd--; end
      end else r_gd--;
    end else if (noise_en) begin
      master_data_gnt_i    = ($urandom_range(0, 3) == 0);
      master_data_rvalid_i = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Enter at (or just after) a negedge, leave at the following negedge.
  task automatic tick();
    bit acc, hs, g, rv;
    logic [DW-1:0] rd;
    respond();
    #1;
    acc = cmd_valid_i && m_live && !m_busy;
    hs  = rsp_ready_i && m_have_rsp;
    g = master_data_gnt_i; rv = master_data_rvalid_i; rd = master_data_rdata_i;
    @(posedge clk);
    model_update(acc, hs, g, rv, rd);
    @(negedge clk);
  endtask

  task automatic run_cmd(input bit we, input logic [AW-1:0] a, input logic [BW-1:0] be,
                         input logic [DW-1:0] wd, input int gd, input int rd, input int bp,
                         input logic [DW-1:0] data, output int lat, output int reqc,
                         output logic [DW-1:0] rdat, output logic err);
    int guard;
    r_gd = -1; r_wait_rv = 0; f_gd = gd; f_rd = rd; f_data_en = 1; f_data = data;
    rsp_ready_i = 0; cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = a; cmd_be_i = be; cmd_wdata_i = wd;
    guard = 0;
    while (!cmd_ready_o && guard < 300) begin tick(); guard++; end
    tick();
    cmd_valid_i = 0;
    lat = 1; reqc = 0;
    while (!rsp_valid_o && guard < 300) begin
      if (master_data_req_o) reqc++;
      tick(); lat++; guard++;
    end
    if (guard >= 300) begin
      checks++; failures++;
      $display("FAIL cmd_wait: no response within 300 cycles for addr 0x%0h", a);
    end
    repeat (bp) tick();
    rdat = rsp_rdata_o; err = rsp_err_o;
    rsp_ready_i = 1; tick(); rsp_ready_i = 0;
    f_gd = -1; f_rd = -1; f_data_en = 0;
  endtask

  initial begin
    int lat, reqc;
    logic [DW-1:0] rdat;
    logic err;
    reset = 0; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = '0; cmd_be_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 0; master_data_gnt_i = 0; master_data_rvalid_i = 0; master_data_rdata_i = '0;
    #2;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_req", master_data_req_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_addr", master_data_addr_o, 0);
    chk("rst_wdata", master_data_wdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk_en = 1;
    @(negedge clk); tick(); tick();
    reset = 1;
    #1 chk("ready_at_release", cmd_ready_o, 0);
    tick();
    chk("ready_after_release", cmd_ready_o, 1);

    run_cmd(1, 10'h004, 4'hF, 32'h0000_1B2C, 1, 0, 0, 32'h0, lat, reqc, rdat, err);
    chk("wr_req_cycles", reqc, 2); chk("wr_latency", lat, 3);
    chk("wr_rdata", rdat, 0);      chk("wr_err", err, 0);

    run_cmd(0, 10'h000, 4'hF, 32'h0, 1, 2, 0, 32'h0000_00A5, lat, reqc, rdat, err);
    chk("rd_req_cycles", reqc, 2); chk("rd_latency", lat, 5);
    chk("rd_rdata", rdat, 32'hA5); chk("rd_err", err, 0);

    run_cmd(0, 10'h006, 4'hF, 32'h0, 0, 0, 0, 32'h1111_1111, lat, reqc, rdat, err);
    chk("mis_req_cycles", reqc, 0); chk("mis_latency", lat, 1);
    chk("mis_rdata", rdat, 0);      chk("mis_err", err, 1);

    run_cmd(0, 10'h008, 4'h3, 32'h0, 0, 0, 5, 32'h1234_5678, lat, reqc, rdat, err);
    chk("bp_latency", lat, 2); chk("bp_rdata", rdat, 32'h1234_5678);
    chk("bp_ready_after", cmd_ready_o, 1);

    // Reset while the request is outstanding.
    r_gd = -1; r_wait_rv = 0; f_gd = 1000; f_rd = 0;
    cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 10'h010;
    tick(); cmd_valid_i = 0; tick(); tick();
    chk("rst_mid_req_before", master_data_req_o, 1);
    #2 reset = 0;
    #1;
    chk("rst_mid_req_async", master_data_req_o, 0);
    chk("rst_mid_ready", cmd_ready_o, 0);
    r_gd = -1; r_wait_rv = 0; f_gd = -1; f_rd = -1;
    tick();
    reset = 1; stale_n = 2;
    tick(); tick();
    run_cmd(0, 10'h020, 4'hF, 32'h0, 0, 1, 0, 32'h0000_005A, lat, reqc, rdat, err);
    chk("post_rst_rdata", rdat, 32'h5A); chk("post_rst_err", err, 0);
    chk("post_rst_latency", lat, 3);

`ifdef PERIPH_BUS_MASTER_TIMEOUT_EN
    run_cmd(0, 10'h030, 4'hF, 32'h0, 1000, 0, 0, 32'h0, lat, reqc, rdat, err);
    chk("to_req_cycles", reqc, 8); chk("to_latency", lat, 9);
    chk("to_err", err, 1);         chk("to_rdata", rdat, 0);
    run_cmd(0, 10'h034, 4'hF, 32'h0, 7, 0, 0, 32'h0000_00C3, lat, reqc, rdat, err);
    chk("to_edge_req_cycles", reqc, 8); chk("to_edge_err", err, 0);
    chk("to_edge_rdata", rdat, 32'hC3);
`endif

    r_gd = -1; r_wait_rv = 0; noise_en = 1;
    for (int c = 0; c < 4000; c++) begin
      cmd_valid_i = ($urandom_range(0, 2) != 0);
      cmd_we_i    = 1'($urandom);
      cmd_addr_i  = AW'($urandom);
      if ($urandom_range(0, 3) != 0) cmd_addr_i[1:0] = 2'b00;
      cmd_be_i    = BW'($urandom);
      cmd_wdata_i = $urandom;
      rsp_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Bus initiator for the data-memory-style peripheral bus (req / gnt / rvalid handshake), the initiator end of the interface our UART peripheral responds on.
- Accepts single read/write commands on a valid/ready command port, runs exactly one bus transaction per command, and returns read data or an error on a valid/ready response port.
- Used by the debug/boot loader path to access peripherals without the core.

Parameters:
- DATA_WIDTH, 32, bus data width in bits.
- ADDR_WIDTH, 10, bus byte-address width.
- TIMEOUT_CYCLES, 64, cycles from req assertion to forced error; used only with the optional feature.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when valid and ready are both high.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_addr_i  input  ADDR_WIDTH  byte address.
- cmd_be_i  input  DATA_WIDTH/8  byte enables.
- cmd_wdata_i  input  DATA_WIDTH  write data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumed when valid and ready are both high.
- rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  output  1  misaligned access or timeout.
- master_data_req_o  output  1  bus request.
- master_data_addr_o  output  ADDR_WIDTH  bus address.
- master_data_we_o  output  1  bus write enable.
- master_data_be_o  output  DATA_WIDTH/8  bus byte enables.
- master_data_wdata_o  output  DATA_WIDTH  bus write data.
- master_data_gnt_i  input  1  grant from responder.
- master_data_rvalid_i  input  1  response valid from responder.
- master_data_rdata_i  input  DATA_WIDTH  read data from responder.

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o = 0 during reset and 1 from the first cycle after reset release. FSM returns to IDLE and the timeout counter clears.
- States: IDLE, REQ, WAIT_RV, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, register we/addr/be/wdata.
  - If addr[1:0] != 0: go to RESP with err = 1, rdata = 0, and issue no bus request.
  - Otherwise go to REQ; master_data_req_o is high from the next cycle.
- REQ:
  - req, addr, we, be, wdata are held stable until gnt is sampled high.
  - gnt and rvalid both high in the same cycle: capture rdata (reads only) and go to RESP.
  - gnt high without rvalid: go to WAIT_RV.
  - req drops in the cycle after gnt is sampled.
  - The responder may hold gnt/rvalid for multiple cycles; only the first sample counts.
- WAIT_RV:
  - req = 0.
  - On rvalid, capture rdata (reads only) and go to RESP.
- RESP:
  - rsp_valid_o = 1; rdata/err held stable until rsp_ready_i.
  - On handshake, go to IDLE; the next command can be accepted in the following cycle.
  - cmd_ready_o = 0 in every state except IDLE.
- Outstanding transactions: one at most; never more than one bus request per command.
- Minimum latency, responder answering 1 cycle after req: accept at T0, req at T1, gnt/rvalid at T2, rsp_valid at T3.
- Read data: rsp_rdata_o is forced to 0 for writes.
- Reset mid-transaction: the transaction is abandoned and req drops immediately (asynchronous). Any late gnt/rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: PERIPH_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and counts every cycle spent in REQ or WAIT_RV.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited gnt/rvalid: req drops, go to RESP with err = 1, rdata = 0.
  - If the awaited signal arrives in the same cycle as expiry, the bus response wins and err = 0.
- Not defined: no counter; waits indefinitely in REQ/WAIT_RV.

Decomposition:
- Shared package periph_bus_pkg:
  - FSM state encoding (2 bits).
  - Alignment mask constant.
  - Default DATA_WIDTH/ADDR_WIDTH constants shared with the peripheral.
- No sub-module required. The timeout counter may be split out as bus_timeout_counter if it is reused elsewhere.

Test Plan:
- Write: addr 0x004, wdata 0x0000_1B2C, be 0xF; responder grants 1 cycle after req with gnt = rvalid -> req high exactly 2 cycles, addr/wdata stable throughout; rsp err = 0, rdata = 0 at T3.
- Read: addr 0x000; responder returns 0x0000_00A5 with gnt at req+1 and rvalid at req+3 -> req drops after gnt; rsp_rdata = 0xA5, err = 0.
- Misaligned: addr 0x006 -> no req ever asserted; rsp err = 1 one cycle after accept.
- Backpressure: rsp_ready_i low for 5 cycles -> rsp_valid/rdata stable, cmd_ready_o = 0 throughout; new command accepted the cycle after the handshake.
- Reset: reset pulled low while in REQ -> req = 0 immediately; after release, a stale rvalid is ignored and the next read completes correctly.
- Timeout (feature on, TIMEOUT_CYCLES = 8): responder never grants -> req drops after 8 cycles; rsp err = 1, rdata = 0. Variant with gnt arriving on the expiry cycle -> err = 0.
